// File: rtl/tl_ul_pkg.sv
// tl_ul_pkg: TL-UL opcode constants plus has-data and beat-count helpers shared by the arbiter and beat counters
package tl_ul_pkg;
  localparam logic [2:0] PUT_FULL = 3'd0;
  localparam logic [2:0] PUT_PARTIAL = 3'd1;
  localparam logic [2:0] ARITH = 3'd2;
  localparam logic [2:0] LOGICAL = 3'd3;
  localparam logic [2:0] GET = 3'd4;
  localparam logic [2:0] ACCESS_ACK = 3'd0;
  localparam logic [2:0] ACCESS_ACK_DATA = 3'd1;
  function automatic logic a_has_data(input logic [2:0] opcode);
    return opcode <= LOGICAL;
  endfunction
  function automatic logic d_has_data(input logic [2:0] opcode);
    return opcode == ACCESS_ACK_DATA;
  endfunction
  function automatic int beats_from_size(input logic [3:0] size, input logic data, input int max_lgsize);
    int lg;
    lg = int'(size) > max_lgsize ? max_lgsize : int'(size);
    return (data && lg > 2) ? 1 << (lg - 2) : 1;
  endfunction
endpackage

// File: rtl/tl_beat_ctr.sv
// tl_beat_ctr: beat position tracker; in clk/rst_n(sync, low)/opcode/size/fire, out first/last flags for the current beat
module tl_beat_ctr
  import tl_ul_pkg::*;
#(
  parameter int MAX_LGSIZE = 6,
  parameter bit IS_D = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] opcode,
  input  logic [3:0] size,
  input  logic       fire,
  output logic       first,
  output logic       last
);
  localparam int CW = (MAX_LGSIZE > 3) ? MAX_LGSIZE - 2 : 1;
  localparam logic [3:0] MAX_SZ = 4'(MAX_LGSIZE);
  logic [CW-1:0] cnt, rem;
  assign rem = CW'(beats_from_size(size, IS_D ? d_has_data(opcode) : a_has_data(opcode), MAX_LGSIZE) - 1);
  assign first = cnt == '0;
  assign last = first ? rem == '0 : cnt == CW'(1);
  always_ff @(posedge clk)
    if (!rst_n) cnt <= '0;
    else if (fire) cnt <= first ? rem : cnt - CW'(1);
  assert property (@(posedge clk) disable iff (!rst_n) fire && first |-> size <= MAX_SZ);
endmodule

// File: rtl/tl_ul_arb2.sv
// tl_ul_arb2: two-requester TL-UL arbiter; r0/r1 A in + D out, one manager A out + D in, rN_inflight debug counts
module tl_ul_arb2
  import tl_ul_pkg::*;
#(
  parameter int SRC_W = 6,
  parameter int MAX_INFLIGHT = 4,
  parameter int MAX_LGSIZE = 6
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             r0_a_valid,
  output logic             r0_a_ready,
  input  logic [2:0]       r0_a_opcode,
  input  logic [2:0]       r0_a_param,
  input  logic [3:0]       r0_a_size,
  input  logic [SRC_W-1:0] r0_a_source,
  input  logic [29:0]      r0_a_address,
  input  logic [3:0]       r0_a_mask,
  input  logic [31:0]      r0_a_data,
  output logic             r0_d_valid,
  input  logic             r0_d_ready,
  output logic [2:0]       r0_d_opcode,
  output logic [1:0]       r0_d_param,
  output logic [3:0]       r0_d_size,
  output logic [SRC_W-1:0] r0_d_source,
  output logic             r0_d_denied,
  output logic             r0_d_corrupt,
  output logic [31:0]      r0_d_data,
  input  logic             r1_a_valid,
  output logic             r1_a_ready,
  input  logic [2:0]       r1_a_opcode,
  input  logic [2:0]       r1_a_param,
  input  logic [3:0]       r1_a_size,
  input  logic [SRC_W-1:0] r1_a_source,
  input  logic [29:0]      r1_a_address,
  input  logic [3:0]       r1_a_mask,
  input  logic [31:0]      r1_a_data,
  output logic             r1_d_valid,
  input  logic             r1_d_ready,
  output logic [2:0]       r1_d_opcode,
  output logic [1:0]       r1_d_param,
  output logic [3:0]       r1_d_size,
  output logic [SRC_W-1:0] r1_d_source,
  output logic             r1_d_denied,
  output logic             r1_d_corrupt,
  output logic [31:0]      r1_d_data,
  output logic             m_a_valid,
  input  logic             m_a_ready,
  output logic [2:0]       m_a_opcode,
  output logic [2:0]       m_a_param,
  output logic [3:0]       m_a_size,
  output logic [SRC_W:0]   m_a_source,
  output logic [29:0]      m_a_address,
  output logic [3:0]       m_a_mask,
  output logic [31:0]      m_a_data,
  input  logic             m_d_valid,
  output logic             m_d_ready,
  input  logic [2:0]       m_d_opcode,
  input  logic [1:0]       m_d_param,
  input  logic [3:0]       m_d_size,
  input  logic [SRC_W:0]   m_d_source,
  input  logic             m_d_denied,
  input  logic             m_d_corrupt,
  input  logic [31:0]      m_d_data,
  output logic [3:0]       r0_inflight,
  output logic [3:0]       r1_inflight
);
  localparam logic [3:0] MAX_IF = 4'(MAX_INFLIGHT);
  logic [3:0] inflight [2];
  logic [1:0] a_valid, elig, inc, dec;
  logic lock, owner, rr_ptr, gnt, gnt_ok, a_fire, a_first, a_last, d_fire, d_first, d_last, tag;
  assign a_valid = {r1_a_valid, r0_a_valid};
  assign elig = a_valid & {inflight[1] < MAX_IF, inflight[0] < MAX_IF};
  assign lock = !a_first;
  // a burst in progress keeps its owner regardless of the inflight limit
  assign gnt = lock ? owner : ((&elig) ? rr_ptr : elig[1]);
  assign gnt_ok = lock | (|elig);
  assign m_a_valid = reset_n & (lock ? a_valid[gnt] : |elig);
  assign r0_a_ready = reset_n & m_a_ready & gnt_ok & !gnt;
  assign r1_a_ready = reset_n & m_a_ready & gnt_ok & gnt;
  assign m_a_opcode = gnt ? r1_a_opcode : r0_a_opcode;
  assign m_a_param = gnt ? r1_a_param : r0_a_param;
  assign m_a_size = gnt ? r1_a_size : r0_a_size;
  assign m_a_source = {gnt, gnt ? r1_a_source : r0_a_source};
  assign m_a_address = gnt ? r1_a_address : r0_a_address;
  assign m_a_mask = gnt ? r1_a_mask : r0_a_mask;
  assign m_a_data = gnt ? r1_a_data : r0_a_data;
  assign a_fire = m_a_valid & m_a_ready;
  assign inc = {a_fire & a_first & gnt, a_fire & a_first & !gnt};
  assign tag = m_d_source[SRC_W];
  assign r0_d_valid = reset_n & m_d_valid & !tag;
  assign r1_d_valid = reset_n & m_d_valid & tag;
  assign m_d_ready = reset_n & (tag ? r1_d_ready : r0_d_ready);
  assign d_fire = m_d_valid & m_d_ready;
  assign dec = {d_fire & d_last & tag, d_fire & d_last & !tag};
  assign r0_d_opcode = m_d_opcode;
  assign r0_d_param = m_d_param;
  assign r0_d_size = m_d_size;
  assign r0_d_source = m_d_source[SRC_W-1:0];
  assign r0_d_denied = m_d_denied;
  assign r0_d_corrupt = m_d_corrupt;
  assign r0_d_data = m_d_data;
  assign r1_d_opcode = m_d_opcode;
  assign r1_d_param = m_d_param;
  assign r1_d_size = m_d_size;
  assign r1_d_source = m_d_source[SRC_W-1:0];
  assign r1_d_denied = m_d_denied;
  assign r1_d_corrupt = m_d_corrupt;
  assign r1_d_data = m_d_data;
  assign r0_inflight = inflight[0];
  assign r1_inflight = inflight[1];
  tl_beat_ctr #(.MAX_LGSIZE(MAX_LGSIZE), .IS_D(1'b0)) u_a_ctr (
    .clk(clock), .rst_n(reset_n), .opcode(m_a_opcode), .size(m_a_size),
    .fire(a_fire), .first(a_first), .last(a_last)
  );
  tl_beat_ctr #(.MAX_LGSIZE(MAX_LGSIZE), .IS_D(1'b1)) u_d_ctr (
    .clk(clock), .rst_n(reset_n), .opcode(m_d_opcode), .size(m_d_size),
    .fire(d_fire), .first(d_first), .last(d_last)
  );
  always_ff @(posedge clock)
    if (!reset_n) begin
      owner <= 1'b0;
      rr_ptr <= 1'b0;
      for (int i = 0; i < 2; i++) inflight[i] <= '0;
    end else begin
      if (a_fire & a_first) owner <= gnt;
      if (a_fire & a_last) rr_ptr <= !gnt;
      for (int i = 0; i < 2; i++)
        if (inc[i] & !dec[i]) inflight[i] <= inflight[i] + 4'd1;
        else if (dec[i] & !inc[i] & (inflight[i] != '0)) inflight[i] <= inflight[i] - 4'd1;
    end
  assert property (@(posedge clock) disable iff (!reset_n) !(dec[0] && !inc[0] && inflight[0] == '0));
  assert property (@(posedge clock) disable iff (!reset_n) !(dec[1] && !inc[1] && inflight[1] == '0));
  assert property (@(posedge clock) disable iff (!reset_n) m_d_valid && !d_first |-> d_has_data(m_d_opcode));
endmodule

// File: doc/tl_ul_arb2.md
Name: tl_ul_arb2

Overview:
- Two-requester TileLink-UL arbiter feeding one 32-bit TL-UL manager port. The manager port has the same A/D channel field set as the existing TL pass-through stage, which sits directly downstream.
- Arbitrates the A channel round-robin, with a lock held for the full length of a multi-beat burst.
- Tags each A-channel source with the requester index. Routes D-channel responses back by that tag.
- Limits in-flight transactions per requester.

Parameters:
SRC_W, 6, requester-side source width; manager side is SRC_W+1.
MAX_INFLIGHT, 4, outstanding-request limit per requester (1..15).
MAX_LGSIZE, 6, largest legal size (64 B = 16 beats); sets the beat-counter width.

Ports:
clock  in  1  single clock.
reset_n  in  1  synchronous, active-low reset.
rN_a_valid/rN_a_ready  in/out  1/1  requester N (N=0,1) A handshake.
rN_a_opcode,param,size,source,address,mask,data  in  3,3,4,SRC_W,30,4,32  requester N A fields.
rN_d_valid/rN_d_ready  out/in  1/1  requester N D handshake.
rN_d_opcode,param,size,source,denied,corrupt,data  out  3,2,4,SRC_W,1,1,32  requester N D fields.
m_a_valid/m_a_ready  out/in  1/1  manager A handshake.
m_a_opcode,param,size,source,address,mask,data  out  3,3,4,SRC_W+1,30,4,32  manager A fields.
m_d_valid/m_d_ready  in/out  1/1  manager D handshake.
m_d_opcode,param,size,source,denied,corrupt,data  in  3,2,4,SRC_W+1,1,1,32  manager D fields.
rN_inflight  out  4  debug: outstanding count for requester N.

Behaviour:
- Reset (reset_n=0 at a clock edge):
  - lock=0, rr_ptr=0 (r0 has priority), beat counters=0, inflight counters=0.
  - Outputs while in reset: all valid/ready outputs 0.
- Eligibility: requester N is eligible when rN_a_valid=1 and inflight_N < MAX_INFLIGHT.
- Grant, when unlocked:
  - Only one requester eligible: grant it.
  - Both eligible: grant the requester that rr_ptr points to.
  - Grant is combinational in the same cycle; zero added latency.
- A-channel datapath:
  - m_a_* = granted requester's fields; m_a_source = {N, rN_a_source}.
  - m_a_valid = granted requester's valid.
  - rN_a_ready = m_a_ready & granted==N. The non-granted requester sees ready=0.
- Beat count: beats = 2^(size-2) if the message carries data and size>2, else 1.
  - A-channel data opcodes: 0, 1, 2, 3.
  - D-channel data opcode: 1 (AccessAckData).
- A-channel burst lock:
  - First-beat handshake of a multi-beat message sets lock=1 and loads the remaining-beat count.
  - Each following handshake decrements the count.
  - Last-beat handshake clears lock and sets rr_ptr to the other requester.
  - A single-beat message updates rr_ptr on its handshake and never sets lock.
  - While locked, grant is frozen. The inflight limit is ignored for the burst already in progress.
- D-channel routing (independent of the A channel):
  - Route by m_d_source[SRC_W]: rN_d_valid = m_d_valid & tag==N.
  - rN_d_* = m_d_* with the tag bit stripped.
  - m_d_ready = r[tag]_d_ready.
  - The D beat counter tracks multi-beat AccessAckData; the manager does not interleave D bursts.
- Inflight counters:
  - +1 on the first-beat A handshake of requester N.
  - −1 on the last-beat D handshake tagged N.
  - Both in the same cycle: value unchanged.
  - Never wraps. Underflow means a protocol error: assertion fires and the counter holds at 0.
- Ready propagation: no valid output depends combinationally on any ready input.
- Reset mid-burst: lock and counters clear; the transaction is abandoned, with no recovery.
- Illegal size (> MAX_LGSIZE): assertion in simulation; the beat count saturates to the maximum.

Decomposition:
- Package tl_ul_pkg:
  - opcode constants (PutFull=0, PutPartial=1, Arith=2, Logical=3, Get=4, AccessAck=0, AccessAckData=1);
  - has_data functions for A and D;
  - beats_from_size function.
- One sub-module: tl_beat_ctr (size/opcode + handshake → first/last flags). Instantiated once for A and once for D.

Test Plan:
- Both requesters send a Get (size=2) every cycle, m_a_ready=1 → grants alternate r0,r1,r0,…; m_a_source[6] toggles.
- r0 sends PutFull size=4 (4 beats) while r1 is valid → m_a carries r0 for 4 consecutive beats; r1 granted on cycle 5.
- r0 sends 4 Gets with no D response → r0_inflight=4 and a 5th Get is not granted. r1 is still granted. A D response tagged 0 drops the count to 3 and re-enables r0.
- Manager returns AccessAckData size=3 with source=0x45 → 2 beats on r1_d with source 0x05; r0_d_valid stays 0; m_d_ready mirrors r1_d_ready.
- Same-cycle last-D-beat and new A handshake for r0 at inflight=2 → inflight stays 2.
- reset_n=0 during beat 2 of a 4-beat burst → next cycle lock=0, counters=0, m_a_valid=0, rr_ptr=0.
